// File: rtl/exp_add_sched_pkg.sv
// posit_pkg: shared posit exponent-path defaults for the exp_adder scheduler.
//   DEF_ES / DEF_K_BITS : exponent field and signed regime widths
//   DEF_MAX_BITS / DEF_OPW : derived sum and packed operand-pair widths
//   *_LSB / *_BIT       : field offsets inside a packed operand pair
//                         {sign_A, k_A, exp_A, sign_B, k_B, exp_B}, MSB first
//   state_e             : scheduler FSM encoding
package posit_pkg;

  localparam int unsigned DEF_ES       = 3;
  localparam int unsigned DEF_K_BITS   = 6;
  localparam int unsigned DEF_MAX_BITS = DEF_ES + DEF_K_BITS;
  localparam int unsigned DEF_HALF     = 1 + DEF_K_BITS + DEF_ES;
  localparam int unsigned DEF_OPW      = 2 * DEF_HALF;

  localparam int unsigned EXP_B_LSB  = 0;
  localparam int unsigned K_B_LSB    = DEF_ES;
  localparam int unsigned SIGN_B_BIT = DEF_ES + DEF_K_BITS;
  localparam int unsigned EXP_A_LSB  = DEF_HALF;
  localparam int unsigned K_A_LSB    = DEF_HALF + DEF_ES;
  localparam int unsigned SIGN_A_BIT = DEF_HALF + DEF_ES + DEF_K_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/exp_add_sched_if.sv
// Request channel bundle for the two posit-multiply front ends.
//   reqN_valid / reqN_op : requester N offers a packed operand pair
//   reqN_ready           : scheduler accepts requester N this cycle
// Modports: master = requester side, slave = scheduler side,
//           arb = handshake-only view used by the round-robin arbiter.
interface exp_add_sched_if #(
  parameter int unsigned OPW = posit_pkg::DEF_OPW
);

  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;

  modport master (
    output req0_valid, req0_op, req1_valid, req1_op,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req1_valid, req1_op,
    output req0_ready, req1_ready
  );

  modport arb (
    input  req0_valid, req1_valid,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/exp_add_sched_arb.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbitration allowed this cycle
//   req        : valid inputs / ready outputs of both requesters
//   gnt        : one-hot grant (equals the readies)
// rr_ptr favours req0 out of reset and points away from the last winner.
module rr_arb2 (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  exp_add_sched_if.arb        req,
  output logic [1:0]          gnt
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt[0]   = en & req.req0_valid & (~req.req1_valid | ~rr_ptr_q);
    gnt[1]   = en & req.req1_valid & (~req.req0_valid |  rr_ptr_q);
    rr_ptr_d = rr_ptr_q;
    if (gnt[0]) begin
      rr_ptr_d = 1'b1;
    end else if (gnt[1]) begin
      rr_ptr_d = 1'b0;
    end
    req.req0_ready = gnt[0];
    req.req1_ready = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/exp_add_sched.sv
// exp_add_sched: shares one exp_adder between two posit-multiply front ends.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req0_* / req1_*       : valid/ready operand-pair request channels
//   ea_*                  : start pulse + operands to exp_adder, done/result back
//   rsp_*                 : tagged valid/ready response (rsp_err = timeout)
//   busy                  : high whenever not IDLE
// Flow: IDLE --accept--> ISSUE --> WAIT --done|timeout--> RESP --rsp_ready--> IDLE
module exp_add_sched
  import posit_pkg::*;
#(
  parameter int unsigned ES       = DEF_ES,
  parameter int unsigned K_BITS   = DEF_K_BITS,
  parameter int unsigned MAX_BITS = ES + K_BITS,
  parameter int unsigned OPW      = 2 * (1 + K_BITS + ES),
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OPW-1:0]      req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OPW-1:0]      req1_op,
  output logic                ea_start,
  output logic [ES-1:0]       ea_exp_A,
  output logic [ES-1:0]       ea_exp_B,
  output logic [K_BITS-1:0]   ea_k_A,
  output logic [K_BITS-1:0]   ea_k_B,
  output logic                ea_sign_A,
  output logic                ea_sign_B,
  input  logic                ea_done,
  input  logic [MAX_BITS:0]   ea_exp_raw,
  input  logic                ea_sign,
  input  logic                ea_nar,
  input  logic                ea_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [MAX_BITS:0]   rsp_exp_raw,
  output logic                rsp_sign,
  output logic                rsp_nar,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned HALF   = 1 + K_BITS + ES;
  localparam int unsigned EB_LSB = 0;
  localparam int unsigned KB_LSB = ES;
  localparam int unsigned SB_BIT = ES + K_BITS;
  localparam int unsigned EA_LSB = HALF;
  localparam int unsigned KA_LSB = HALF + ES;
  localparam int unsigned SA_BIT = HALF + ES + K_BITS;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  exp_add_sched_if #(.OPW(OPW)) req_if ();

  assign req_if.req0_valid = req0_valid;
  assign req_if.req0_op    = req0_op;
  assign req_if.req1_valid = req1_valid;
  assign req_if.req1_op    = req1_op;
  assign req0_ready        = req_if.req0_ready;
  assign req1_ready        = req_if.req1_ready;

  state_e             state_q,        state_d;
  logic [OPW-1:0]     hold_op_q,      hold_op_d;
  logic               hold_id_q,      hold_id_d;
  logic [CNT_W-1:0]   wait_cnt_q,     wait_cnt_d;
  logic [MAX_BITS:0]  rsp_exp_raw_q,  rsp_exp_raw_d;
  logic               rsp_sign_q,     rsp_sign_d;
  logic               rsp_nar_q,      rsp_nar_d;
  logic               rsp_zero_q,     rsp_zero_d;
  logic               rsp_err_q,      rsp_err_d;
  logic [1:0]         gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_IDLE),
    .req   (req_if),
    .gnt   (gnt)
  );

  always_comb begin
    state_d       = state_q;
    hold_op_d     = hold_op_q;
    hold_id_d     = hold_id_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_exp_raw_d = rsp_exp_raw_q;
    rsp_sign_d    = rsp_sign_q;
    rsp_nar_d     = rsp_nar_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_err_d     = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          hold_op_d = gnt[1] ? req_if.req1_op : req_if.req0_op;
          hold_id_d = gnt[1];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // done takes priority over a timeout in the same cycle; the
        // exp_adder flags are only valid while done is high
        if (ea_done) begin
          rsp_exp_raw_d = ea_exp_raw;
          rsp_sign_d    = ea_sign;
          rsp_nar_d     = ea_nar;
          rsp_zero_d    = ea_zero;
          rsp_err_d     = 1'b0;
          state_d       = ST_RESP;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_exp_raw_d = '0;
          rsp_sign_d    = 1'b0;
          rsp_nar_d     = 1'b0;
          rsp_zero_d    = 1'b0;
          rsp_err_d     = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold_op_q     <= '0;
      hold_id_q     <= 1'b0;
      wait_cnt_q    <= '0;
      rsp_exp_raw_q <= '0;
      rsp_sign_q    <= 1'b0;
      rsp_nar_q     <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_op_q     <= hold_op_d;
      hold_id_q     <= hold_id_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_exp_raw_q <= rsp_exp_raw_d;
      rsp_sign_q    <= rsp_sign_d;
      rsp_nar_q     <= rsp_nar_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // operands change only on accept, so they stay stable through ISSUE and WAIT
  assign ea_sign_A   = hold_op_q[SA_BIT];
  assign ea_k_A      = hold_op_q[KA_LSB +: K_BITS];
  assign ea_exp_A    = hold_op_q[EA_LSB +: ES];
  assign ea_sign_B   = hold_op_q[SB_BIT];
  assign ea_k_B      = hold_op_q[KB_LSB +: K_BITS];
  assign ea_exp_B    = hold_op_q[EB_LSB +: ES];

  assign ea_start    = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_id      = hold_id_q;
  assign rsp_exp_raw = rsp_exp_raw_q;
  assign rsp_sign    = rsp_sign_q;
  assign rsp_nar     = rsp_nar_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_exp_add_sched.sv
// Testbench for exp_add_sched: directed table, multi-cycle corner sequences
// and a randomized phase against a transaction-level reference model.
// An exp_adder stand-in answers each start with a done pulse 4 cycles later.
module tb_exp_add_sched;
  import posit_pkg::*;

  localparam int unsigned ES  = DEF_ES;
  localparam int unsigned KB  = DEF_K_BITS;
  localparam int unsigned MB  = DEF_MAX_BITS;
  localparam int unsigned OPW = DEF_OPW;

  typedef struct {
    logic [MB:0] raw;
    logic        sign;
    logic        nar;
    logic        zero;
  } res_t;

  typedef struct {
    logic           id;
    logic [OPW-1:0] op;
    logic [MB:0]    raw;
    logic           sign;
    logic           nar;
    logic           zero;
  } vec_t;

  typedef struct {
    logic           id;
    logic [OPW-1:0] op;
    int             acc;
  } job_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exp_add_sched_if #(.OPW(OPW)) rq ();

  logic            ea_start, ea_sign_A, ea_sign_B, ea_done, ea_sign, ea_nar, ea_zero;
  logic [ES-1:0]   ea_exp_A, ea_exp_B;
  logic [KB-1:0]   ea_k_A, ea_k_B;
  logic [MB:0]     ea_exp_raw;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_sign, rsp_nar, rsp_zero, rsp_err, busy;
  logic [MB:0]     rsp_exp_raw;

  exp_add_sched #(.ES(ES), .K_BITS(KB), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rq.req0_valid), .req0_ready(rq.req0_ready), .req0_op(rq.req0_op),
    .req1_valid(rq.req1_valid), .req1_ready(rq.req1_ready), .req1_op(rq.req1_op),
    .ea_start(ea_start), .ea_exp_A(ea_exp_A), .ea_exp_B(ea_exp_B),
    .ea_k_A(ea_k_A), .ea_k_B(ea_k_B), .ea_sign_A(ea_sign_A), .ea_sign_B(ea_sign_B),
    .ea_done(ea_done), .ea_exp_raw(ea_exp_raw), .ea_sign(ea_sign), .ea_nar(ea_nar),
    .ea_zero(ea_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_exp_raw(rsp_exp_raw), .rsp_sign(rsp_sign), .rsp_nar(rsp_nar),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // exponent sum of a packed operand pair: (k_A+k_B)*2^ES + exp_A + exp_B
  function automatic res_t model(input logic [OPW-1:0] op);
    res_t        r;
    int          ka, kb, ea, eb, s;
    logic [31:0] sv;
    ka = $signed(op[K_A_LSB +: KB]);
    kb = $signed(op[K_B_LSB +: KB]);
    ea = int'(op[EXP_A_LSB +: ES]);
    eb = int'(op[EXP_B_LSB +: ES]);
    s  = (ka + kb) * (1 << ES) + ea + eb;
    sv = s;
    r.raw  = sv[MB:0];
    r.sign = op[SIGN_A_BIT] ^ op[SIGN_B_BIT];
    r.nar  = (s > 255);
    r.zero = (s < -256);
    return r;
  endfunction

  function automatic logic [OPW-1:0] pk(input bit sa, input int ka, input int ea,
                                        input bit sb, input int kb, input int eb);
    logic [31:0] kav, eav, kbv, ebv;
    kav = ka; eav = ea; kbv = kb; ebv = eb;
    return {sa, kav[KB-1:0], eav[ES-1:0], sb, kbv[KB-1:0], ebv[ES-1:0]};
  endfunction

  // ---------------- exp_adder stand-in ----------------
  logic [2:0]  st_cnt;
  logic        st_done, st_sign, st_nar, st_zero;
  logic [MB:0] st_raw;
  logic        stub_mute, late_done;
  res_t        stub_r;

  always_comb stub_r = model({ea_sign_A, ea_k_A, ea_exp_A, ea_sign_B, ea_k_B, ea_exp_B});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt <= '0; st_done <= 1'b0; st_raw <= '0;
      st_sign <= 1'b0; st_nar <= 1'b0; st_zero <= 1'b0;
    end else begin
      st_done <= 1'b0; st_raw <= '0; st_sign <= 1'b0; st_nar <= 1'b0; st_zero <= 1'b0;
      if (ea_start) begin
        st_cnt <= 3'd3;
      end else if (st_cnt != 0) begin
        st_cnt <= st_cnt - 3'd1;
        if (st_cnt == 3'd1 && !stub_mute) begin
          st_done <= 1'b1;
          st_raw  <= stub_r.raw;
          st_sign <= stub_r.sign;
          st_nar  <= stub_r.nar;
          st_zero <= stub_r.zero;
        end
      end
    end
  end

  assign ea_done    = st_done | late_done;
  assign ea_exp_raw = st_raw;
  assign ea_sign    = st_sign;
  assign ea_nar     = st_nar;
  assign ea_zero    = st_zero;

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc_in();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_out();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rsp_vec();
    return {17'd0, rsp_id, rsp_exp_raw, rsp_sign, rsp_nar, rsp_zero, rsp_err};
  endfunction

  function automatic logic [31:0] exp_vec(input logic id, input res_t r, input logic err);
    return {17'd0, id, r.raw, r.sign, r.nar, r.zero, err};
  endfunction

  task automatic do_reset();
    cyc_in();
    rst_n = 1'b0;
    cyc_in();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    rq.req0_valid = 1'b0;
    rq.req1_valid = 1'b0;
    rsp_ready     = 1'b1;
    repeat (n) cyc_in();
  endtask

  // ---------------- random-phase reference model ----------------
  job_t jq[$];
  bit   m_free;
  bit   m_ptr;
  bit   m_seen;
  int   cyc;

  task automatic rnd_cycle(input bit v0, input bit v1, input logic [OPW-1:0] o0,
                           input logic [OPW-1:0] o1, input bit rr);
    bit   e0, e1;
    job_t j;
    cyc_in();
    rq.req0_valid = v0; rq.req1_valid = v1;
    rq.req0_op = o0;    rq.req1_op = o1;
    rsp_ready = rr;
    cyc_out();
    cyc++;
    // scheduler is free only between a response handshake and the next accept
    e0 = m_free && v0 && (!v1 || !m_ptr);
    e1 = m_free && v1 && (!v0 || m_ptr);
    chk("rnd_ready", {30'd0, rq.req1_ready, rq.req0_ready}, {30'd0, e1, e0});
    if (rsp_valid) begin
      if (jq.size() == 0) begin
        chk("rnd_spurious_rsp", 32'd1, 32'd0);
      end else begin
        if (!m_seen) begin
          chk("rnd_latency", cyc - jq[0].acc, 32'd6);
          m_seen = 1'b1;
        end
        chk("rnd_rsp", rsp_vec(), exp_vec(jq[0].id, model(jq[0].op), 1'b0));
        if (rr) begin
          void'(jq.pop_front());
          m_seen = 1'b0;
          m_free = 1'b1;
        end
      end
    end else if (jq.size() != 0 && (cyc - jq[0].acc) > 6 && !m_seen) begin
      chk("rnd_rsp_missing", 32'd0, 32'd1);
      m_seen = 1'b1;
    end
    if (e0 || e1) begin
      j.id = e1; j.op = e1 ? o1 : o0; j.acc = cyc;
      jq.push_back(j);
      m_free = 1'b0;
      m_ptr  = ~e1;
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tv[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [OPW-1:0] opa, opb;
    int             starts, early, n;
    logic           g_q[$];
    logic           r_q[$];
    res_t           ra, rb;

    rq.req0_valid = 1'b0; rq.req1_valid = 1'b0;
    rq.req0_op = '0;      rq.req1_op = '0;
    rsp_ready = 1'b1; stub_mute = 1'b0; late_done = 1'b0;

    tv[0] = '{1'b0, pk(0, 1, 2, 1, 2, 3),       10'd29,  1'b1, 1'b0, 1'b0};
    tv[1] = '{1'b1, pk(0, 29, 7, 0, 29, 7),     10'd478, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b0, pk(1, -30, 0, 1, -30, 0),   10'd544, 1'b0, 1'b0, 1'b1};
    tv[3] = '{1'b1, pk(1, -2, 5, 0, 3, 1),      10'd14,  1'b1, 1'b0, 1'b0};

    // reset state
    cyc_out();
    chk("rst_ctrl", {28'd0, busy, rsp_valid, ea_start, rsp_id}, 32'd0);
    chk("rst_ea_ops", {12'd0, ea_sign_A, ea_k_A, ea_exp_A, ea_sign_B, ea_k_B, ea_exp_B}, 32'd0);
    chk("rst_rsp", rsp_vec(), 32'd0);
    cyc_in();
    rst_n = 1'b1;

    // directed table: single op on an idle scheduler, full latency profile
    for (int v = 0; v < 4; v++) begin
      cyc_in();
      if (tv[v].id) begin rq.req1_valid = 1'b1; rq.req1_op = tv[v].op; end
      else          begin rq.req0_valid = 1'b1; rq.req0_op = tv[v].op; end
      cyc_out();
      chk("tbl_accept", {30'd0, rq.req1_ready, rq.req0_ready},
          tv[v].id ? 32'd2 : 32'd1);
      cyc_in();
      rq.req0_valid = 1'b0; rq.req1_valid = 1'b0;
      starts = 0; early = 0;
      for (int c = 1; c <= 7; c++) begin
        if (c > 1) cyc_in();
        cyc_out();
        if (ea_start) starts++;
        if (c == 1) begin
          chk("tbl_start_T1", {31'd0, ea_start}, 32'd1);
          chk("tbl_ea_ops", {12'd0, ea_sign_A, ea_k_A, ea_exp_A, ea_sign_B, ea_k_B, ea_exp_B},
              {12'd0, tv[v].op});
        end
        if (c < 6 && rsp_valid) early++;
        if (c == 6) begin
          chk("tbl_rsp_valid_T6", {31'd0, rsp_valid}, 32'd1);
          chk("tbl_rsp", rsp_vec(),
              {17'd0, tv[v].id, tv[v].raw, tv[v].sign, tv[v].nar, tv[v].zero, 1'b0});
        end
        if (c == 7) chk("tbl_rsp_drop", {30'd0, busy, rsp_valid}, 32'd0);
      end
      chk("tbl_start_once", starts, 32'd1);
      chk("tbl_no_early_rsp", early, 32'd0);
    end

    // both requesters valid continuously from reset: alternating grants
    do_reset();
    opa = pk(0, 3, 1, 0, -1, 6);
    opb = pk(1, -5, 4, 0, 7, 2);
    rq.req0_op = opa; rq.req1_op = opb;
    rq.req0_valid = 1'b1; rq.req1_valid = 1'b1; rsp_ready = 1'b1;
    ra = model(opa); rb = model(opb);
    for (int c = 0; c < 28; c++) begin
      if (c > 0) cyc_in();
      cyc_out();
      if (rq.req0_ready) g_q.push_back(1'b0);
      if (rq.req1_ready) g_q.push_back(1'b1);
      if (rsp_valid) begin
        r_q.push_back(rsp_id);
        chk("alt_rsp", rsp_vec(), exp_vec(rsp_id, rsp_id ? rb : ra, 1'b0));
      end
    end
    chk("alt_grants", g_q.size(), 32'd4);
    chk("alt_rsps", r_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_q.size()) chk("alt_grant_order", {31'd0, g_q[i]}, i % 2);
      if (i < r_q.size()) chk("alt_rsp_order", {31'd0, r_q[i]}, i % 2);
    end
    cyc_in();
    rq.req0_valid = 1'b0; rq.req1_valid = 1'b0;

    // backpressure: response held 10 cycles, no grants until after handshake
    cyc_in();
    rsp_ready = 1'b0;
    rq.req0_valid = 1'b1; rq.req1_valid = 1'b1;
    cyc_out();
    chk("bp_grant0", {30'd0, rq.req1_ready, rq.req0_ready}, 32'd1);
    n = 0;
    do begin
      cyc_in();
      cyc_out();
      n++;
    end while (!rsp_valid && n < 12);
    chk("bp_rsp_latency", n, 32'd6);
    for (int c = 0; c < 10; c++) begin
      cyc_in();
      cyc_out();
      chk("bp_hold", {rsp_valid, rq.req0_ready, rq.req1_ready, rsp_vec()[28:0]},
          {1'b1, 1'b0, 1'b0, exp_vec(1'b0, ra, 1'b0)[28:0]});
    end
    cyc_in();
    rsp_ready = 1'b1;
    cyc_out();
    chk("bp_handshake", {29'd0, rsp_valid, rq.req1_ready, rq.req0_ready}, 32'd4);
    cyc_in();
    cyc_out();
    chk("bp_next_grant", {29'd0, rsp_valid, rq.req1_ready, rq.req0_ready}, 32'd2);
    drain(8);

    // timeout: exp_adder never answers, then a late done in IDLE
    stub_mute = 1'b1;
    rq.req0_op = opa; rq.req0_valid = 1'b1;
    cyc_out();
    chk("to_accept", {31'd0, rq.req0_ready}, 32'd1);
    cyc_in();
    rq.req0_valid = 1'b0;
    n = 1;
    cyc_out();
    while (!rsp_valid && n < 40) begin
      cyc_in();
      cyc_out();
      n++;
    end
    chk("to_latency", n, 32'd18);
    chk("to_rsp", rsp_vec(), 32'd1);
    cyc_in();
    stub_mute = 1'b0;
    late_done = 1'b1;
    cyc_out();
    chk("to_idle_at_late_done", {30'd0, busy, rsp_valid}, 32'd0);
    cyc_in();
    late_done = 1'b0;
    early = 0;
    for (int c = 0; c < 4; c++) begin
      cyc_out();
      if (rsp_valid || busy) early++;
      cyc_in();
    end
    chk("to_late_done_ignored", early, 32'd0);

    // reset during WAIT (rr_ptr currently favours req1)
    rq.req0_op = opb; rq.req0_valid = 1'b1;
    cyc_out();
    chk("rw_accept", {31'd0, rq.req0_ready}, 32'd1);
    cyc_in();
    rq.req0_valid = 1'b0;
    cyc_in();
    cyc_in();
    rst_n = 1'b0;
    cyc_out();
    chk("rw_ctrl", {28'd0, busy, rsp_valid, ea_start, rsp_id}, 32'd0);
    chk("rw_ea_ops", {12'd0, ea_sign_A, ea_k_A, ea_exp_A, ea_sign_B, ea_k_B, ea_exp_B}, 32'd0);
    chk("rw_rsp", rsp_vec(), 32'd0);
    cyc_in();
    rst_n = 1'b1;
    early = 0;
    for (int c = 0; c < 8; c++) begin
      cyc_out();
      if (rsp_valid || busy) early++;
      cyc_in();
    end
    chk("rw_no_rsp", early, 32'd0);
    rq.req0_valid = 1'b1; rq.req1_valid = 1'b1;
    cyc_out();
    chk("rw_first_grant_req0", {30'd0, rq.req1_ready, rq.req0_ready}, 32'd1);
    cyc_in();
    drain(10);

    // randomized traffic against the transaction-level model
    do_reset();
    m_free = 1'b1; m_ptr = 1'b0; m_seen = 1'b0; cyc = 0;
    for (int i = 0; i < 900; i++) begin
      rnd_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                OPW'($urandom), OPW'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) rnd_cycle(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rnd_all_answered", jq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_add_sched.md
Name: exp_add_sched

Overview:
- Two-requester scheduler that shares a single exp_adder instance between two posit-multiply front ends.
- Arbitrates round-robin, holds the winning operands and issues a one-cycle start to exp_adder.
- Captures the single-cycle done/result, then returns a tagged response over a valid/ready channel.
- Includes a watchdog so a lost done cannot hang either requester.

Parameters:
- ES, 3, posit exponent field width (must match exp_adder).
- K_BITS, 6, signed regime width (must match exp_adder).
- MAX_BITS, ES+K_BITS, derived; result exp_raw width is MAX_BITS+1.
- OPW, 2*(1+K_BITS+ES), derived; packed operand width = 20 at defaults.
- TIMEOUT, 16, max WAIT cycles before error response; must be at least 5.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_op  in  OPW  packed operands {sign_A, k_A, exp_A, sign_B, k_B, exp_B}, MSB first
- req1_valid, req1_ready, req1_op  same as above for requester 1
- ea_start  out  1  start pulse to exp_adder
- ea_exp_A, ea_exp_B  out  ES  operand exponent fields
- ea_k_A, ea_k_B  out  K_BITS  signed regime values
- ea_sign_A, ea_sign_B  out  1  operand signs
- ea_done  in  1  exp_adder done pulse
- ea_exp_raw  in  MAX_BITS+1  exp_adder sum
- ea_sign, ea_nar, ea_zero  in  1  exp_adder sign_out, NaR, zero_out
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index owning the response
- rsp_exp_raw  out  MAX_BITS+1  captured sum
- rsp_sign, rsp_nar, rsp_zero, rsp_err  out  1  captured flags; rsp_err=timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n = 0): state IDLE; operand hold register and ea_* operand outputs 0; ea_start 0; rsp_* 0; busy 0; rr_ptr=0 (favours req0); wait counter 0. Reset mid-operation discards the job with no response. exp_adder shares rst_n.
- States:
  - IDLE -> ISSUE on accept.
  - ISSUE -> WAIT unconditionally.
  - WAIT -> RESP when ea_done=1 or when wait counter = TIMEOUT-1.
  - RESP -> IDLE when rsp_ready=1.
- Arbitration in IDLE only:
  - req0_ready = IDLE & req0_valid & (!req1_valid | rr_ptr==0).
  - req1_ready = IDLE & req1_valid & (!req0_valid | rr_ptr==1).
  - Readies are 0 in all other states.
  - On accept of requester g: latch op and g into the hold register; rr_ptr <= ~g.
- ea_start is combinationally 1 only in ISSUE, giving exactly one cycle per job.
- ea_* operand outputs are driven from the hold register and stay stable from ISSUE until the state leaves WAIT. exp_adder samples them in its INIT cycle.
- WAIT:
  - Counter increments every cycle and clears on entry.
  - ea_done=1: capture ea_exp_raw, ea_sign, ea_nar and ea_zero in the same edge; rsp_err <= 0. The flags are valid only while done=1 because exp_adder clears them one cycle later.
  - Timeout: rsp_exp_raw, rsp_sign, rsp_nar, rsp_zero <= 0; rsp_err <= 1.
  - ea_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1; rsp_id = held g. All rsp_* stay stable until rsp_ready.
  - rsp_valid drops the cycle after the handshake.
- ea_done seen outside WAIT (late after a timeout) is ignored; no state change.
- Latency: accept in cycle T -> ea_start in T+1 -> ea_done in T+5 -> rsp_valid in T+6. Minimum issue interval is 7 cycles with rsp_ready tied high.
- No new accept while busy. Requester valids may deassert freely; requesters are not required to hold valid.

Decomposition:
- Shared package posit_pkg holds:
  - ES and K_BITS defaults, and the derived MAX_BITS and OPW.
  - Operand field offsets within req*_op.
  - The state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11.
- One natural sub-module, rr_arb2: two-input round-robin arbiter with en, rr_ptr update and one-hot grant.
- Counter and result capture stay in the top module.

Test Plan:
- Single op, req0_op with k_A=1, exp_A=2, k_B=2, exp_B=3, signs 0/1, against the real exp_adder -> ea_start high exactly 1 cycle at T+1; rsp_valid at T+6 with rsp_id=0, rsp_exp_raw=29, rsp_sign=1, nar=0, zero=0, err=0.
- Both valid every cycle from reset with rsp_ready=1 -> grants alternate 0,1,0,1; 4 responses in 28 cycles, ids in grant order.
- Overflow: k_A=k_B=29, exp=7 each -> rsp_nar=1, rsp_exp_raw=478. Underflow: k_A=k_B=-30, exp=0 -> rsp_zero=1.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable and both readies 0 throughout; the next grant comes the cycle after the handshake.
- Stub exp_adder never asserts done -> rsp_valid with rsp_err=1 and rsp_exp_raw=0 after 16 WAIT cycles; a late ea_done pulse in IDLE causes no response.
- rst_n low during WAIT -> all outputs return to reset values at once; no response after release; the first new grant goes to req0.
